// File: rtl/cpu_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : cpu_trace_monitor
// Purpose  : Run monitor beside the CPU; counts RUN cycles, detects halt or
//            cycle-limit, and captures register/memory writes into a FIFO.
// Revision : 1.0  initial release
// ============================================================================
module cpu_trace_monitor #(
    parameter int PC_W        = 32,
    parameter int DATA_W      = 32,
    parameter int RADDR_W     = 5,
    parameter int DEPTH       = 16,
    parameter int MAX_CYCLES  = 400,
    parameter int HALT_CYCLES = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [PC_W-1:0]    pc_i,
    input  logic               rf_we_i,
    input  logic [RADDR_W-1:0] rf_waddr_i,
    input  logic [DATA_W-1:0]  rf_wdata_i,
    input  logic               mem_we_i,
    input  logic [DATA_W-1:0]  mem_addr_i,
    input  logic [DATA_W-1:0]  mem_wdata_i,
    output logic               trc_valid_o,
    input  logic               trc_ready_i,
    output logic               trc_kind_o,
    output logic [PC_W-1:0]    trc_pc_o,
    output logic [DATA_W-1:0]  trc_addr_o,
    output logic [DATA_W-1:0]  trc_data_o,
    output logic [1:0]         state_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic               overflow_o,
    output logic [31:0]        cycle_cnt_o,
    output logic [15:0]        drop_cnt_o
);

    localparam int c_PTR_W   = $clog2(DEPTH);
    localparam int c_CNT_W   = c_PTR_W + 1;
    localparam int c_SAME_W  = $clog2(HALT_CYCLES + 1);
    localparam int c_ENTRY_W = 1 + PC_W + 2 * DATA_W;
    localparam logic [c_CNT_W-1:0]  c_DEPTH = c_CNT_W'(DEPTH);
    localparam logic [c_SAME_W-1:0] c_HALT  = c_SAME_W'(HALT_CYCLES);
    localparam logic [31:0]         c_MAX   = 32'(MAX_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [31:0]            r_cycle_cnt;
    logic [15:0]            r_drop_cnt;
    logic                   r_overflow, r_timeout, r_pc_valid;
    logic [PC_W-1:0]        r_prev_pc;
    logic [c_SAME_W-1:0]    r_same_cnt;
    logic [c_PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;
    logic [c_ENTRY_W-1:0]   r_fifo [DEPTH];

    logic                   w_in_run, w_enter_run, w_halt, w_tmo;
    logic [31:0]            w_cyc_nxt;
    logic [c_SAME_W-1:0]    w_same_nxt;
    logic                   w_pop, w_ev_rf, w_ev_mem, w_push0, w_push1;
    logic [1:0]             w_push_n, w_ndrop;
    logic [c_CNT_W-1:0]     w_free;
    logic [c_ENTRY_W-1:0]   w_e_rf, w_e_mem, w_e0;
    logic [c_PTR_W-1:0]     w_wr_ptr1;
    logic [16:0]            w_drop_sum;

    assign w_in_run   = (r_state == ST_RUN);
    assign w_cyc_nxt  = r_cycle_cnt + 32'd1;
    assign w_same_nxt = (r_pc_valid && (pc_i == r_prev_pc)) ? r_same_cnt + c_SAME_W'(1) : '0;
    assign w_halt     = w_in_run && (w_same_nxt == c_HALT);
    assign w_tmo      = w_in_run && (w_cyc_nxt == c_MAX);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (start_i) w_state_nxt = ST_RUN;
            ST_RUN:  if (w_halt || w_tmo) w_state_nxt = ST_DONE;
            ST_DONE: if (start_i) w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_enter_run = !w_in_run && (w_state_nxt == ST_RUN);

    // Event arbitration: register write always takes the first free slot.
    assign w_pop    = trc_valid_o && trc_ready_i;
    assign w_free   = c_DEPTH - r_count + c_CNT_W'(w_pop);
    assign w_ev_rf  = w_in_run && rf_we_i && (rf_waddr_i != '0);
    assign w_ev_mem = w_in_run && mem_we_i;
    assign w_e_rf   = {1'b0, pc_i, DATA_W'(rf_waddr_i), rf_wdata_i};
    assign w_e_mem  = {1'b1, pc_i, mem_addr_i, mem_wdata_i};

    always_comb begin
        w_push0 = 1'b0;
        w_push1 = 1'b0;
        w_ndrop = 2'd0;
        w_e0    = w_e_rf;
        if (w_ev_rf && w_ev_mem) begin
            if (w_free >= c_CNT_W'(2)) begin
                w_push0 = 1'b1;
                w_push1 = 1'b1;
            end else if (w_free == c_CNT_W'(1)) begin
                w_push0 = 1'b1;
                w_ndrop = 2'd1;
            end else begin
                w_ndrop = 2'd2;
            end
        end else if (w_ev_rf || w_ev_mem) begin
            w_e0 = w_ev_rf ? w_e_rf : w_e_mem;
            if (w_free != '0) w_push0 = 1'b1;
            else              w_ndrop = 2'd1;
        end
    end

    assign w_push_n   = {1'b0, w_push0} + {1'b0, w_push1};
    assign w_wr_ptr1  = r_wr_ptr + c_PTR_W'(1);
    assign w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_ndrop);

    always_ff @(posedge clk_i) begin
        if (w_push0) r_fifo[r_wr_ptr]  <= w_e0;
        if (w_push1) r_fifo[w_wr_ptr1] <= w_e_mem;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_enter_run) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(w_push_n);
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(w_pop);
            r_count  <= r_count + c_CNT_W'(w_push_n) - c_CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cycle_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
            r_pc_valid  <= 1'b0;
            r_prev_pc   <= '0;
            r_same_cnt  <= '0;
        end else if (w_enter_run) begin
            r_cycle_cnt <= '0;
            r_drop_cnt  <= '0;
            r_overflow  <= 1'b0;
            r_timeout   <= 1'b0;
            r_pc_valid  <= 1'b0;
            r_prev_pc   <= '0;
            r_same_cnt  <= '0;
        end else if (w_in_run) begin
            r_cycle_cnt <= w_cyc_nxt;
            r_same_cnt  <= w_same_nxt;
            r_prev_pc   <= pc_i;
            r_pc_valid  <= 1'b1;
            r_timeout   <= w_tmo && !w_halt;
            r_drop_cnt  <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
            if (w_ndrop != 2'd0) r_overflow <= 1'b1;
        end
    end

    // Data outputs are gated so reset and an empty FIFO present all zeros.
    assign trc_valid_o = (r_count != '0);
    assign {trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o} =
        trc_valid_o ? r_fifo[r_rd_ptr] : '0;
    assign state_o     = r_state;
    assign done_o      = (r_state == ST_DONE);
    assign timeout_o   = r_timeout;
    assign overflow_o  = r_overflow;
    assign cycle_cnt_o = r_cycle_cnt;
    assign drop_cnt_o  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_cpu_trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_trace_monitor
// Purpose  : Self-checking bench for cpu_trace_monitor with a queue-based model.
// Revision : 1.0  initial release
// ============================================================================
module tb_cpu_trace_monitor;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic        rf_we_i = 1'b0;
    logic [4:0]  rf_waddr_i = '0;
    logic [31:0] rf_wdata_i = '0;
    logic        mem_we_i = 1'b0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic        trc_ready_i = 1'b0;
    logic        trc_valid_o, trc_kind_o, done_o, timeout_o, overflow_o;
    logic [31:0] trc_pc_o, trc_addr_o, trc_data_o, cycle_cnt_o;
    logic [1:0]  state_o;
    logic [15:0] drop_cnt_o;

    cpu_trace_monitor dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i),
        .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .rf_wdata_i(rf_wdata_i),
        .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .trc_valid_o(trc_valid_o), .trc_ready_i(trc_ready_i), .trc_kind_o(trc_kind_o),
        .trc_pc_o(trc_pc_o), .trc_addr_o(trc_addr_o), .trc_data_o(trc_data_o),
        .state_o(state_o), .done_o(done_o), .timeout_o(timeout_o),
        .overflow_o(overflow_o), .cycle_cnt_o(cycle_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;
    bit pc_auto  = 1'b1;

    typedef struct packed {
        logic        kind;
        logic [31:0] pc;
        logic [31:0] addr;
        logic [31:0] data;
    } ent_t;

    // Reference model: run status plus a plain queue standing in for the FIFO.
    ent_t        q[$];
    logic [1:0]  m_state;
    int          m_cyc, m_same;
    logic [15:0] m_drop;
    bit          m_ovf, m_tmo, m_pcv;
    logic [31:0] m_prev;

    function automatic void model_reset();
        m_state = 2'd0; m_cyc = 0; m_same = 0; m_drop = '0;
        m_ovf = 0; m_tmo = 0; m_pcv = 0; m_prev = '0;
        q.delete();
    endfunction

    function automatic void model_push(ent_t e);
        if (q.size() < 16) q.push_back(e);
        else begin
            if (m_drop != 16'hFFFF) m_drop++;
            m_ovf = 1;
        end
    endfunction

    function automatic void model_step();
        bit halt, tmo;
        if (q.size() != 0 && trc_ready_i) void'(q.pop_front());
        if (m_state != 2'd1) begin
            if (start_i) begin
                model_reset();
                m_state = 2'd1;
            end
        end else begin
            if (rf_we_i && rf_waddr_i != 0) model_push({1'b0, pc_i, {27'd0, rf_waddr_i}, rf_wdata_i});
            if (mem_we_i) model_push({1'b1, pc_i, mem_addr_i, mem_wdata_i});
            m_cyc++;
            if (m_pcv && pc_i == m_prev) m_same++;
            else m_same = 0;
            m_prev = pc_i;
            m_pcv  = 1;
            halt = (m_same == 4);
            tmo  = (m_cyc == 400);
            if (halt || tmo) begin
                m_state = 2'd2;
                m_tmo   = tmo && !halt;
            end
        end
    endfunction

    task automatic step();
        if (pc_auto) pc_i = pc_i + 32'd4;
        model_step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_events(input bit rf, input logic [4:0] ra, input logic [31:0] rd,
                              input bit mw, input logic [31:0] ma, input logic [31:0] md);
        rf_we_i = rf; rf_waddr_i = ra; rf_wdata_i = rd;
        mem_we_i = mw; mem_addr_i = ma; mem_wdata_i = md;
    endtask

    task automatic do_reset();
        #2 rst_i = 1'b0;
        start_i = 0; trc_ready_i = 0;
        set_events(0, 0, 0, 0, 0, 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        model_reset();
    endtask

    task automatic start_run();
        start_i = 1'b1;
        step();
        start_i = 1'b0;
    endtask

    task automatic fill(input int n_dual, input int n_single);
        trc_ready_i = 0;
        for (int i = 0; i < n_dual; i++) begin
            set_events(1, 5'(i + 1), 32'(100 + i), 1, 32'(i * 4), 32'(200 + i));
            step();
        end
        for (int i = 0; i < n_single; i++) begin
            set_events(1, 5'd9, 32'(300 + i), 0, 0, 0);
            step();
        end
        set_events(0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({state_o, done_o, timeout_o, overflow_o, cycle_cnt_o, drop_cnt_o, trc_valid_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_status: got st=%0d dn=%0d to=%0d ov=%0d cyc=%0d drop=%0d v=%0d, expected all 0",
                     state_o, done_o, timeout_o, overflow_o, cycle_cnt_o, drop_cnt_o, trc_valid_o);
        end
        n_checks++;
        if ({trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o} !== '0) begin
            n_errors++;
            $display("FAIL reset_trc: got %h, expected 0", {trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o});
        end
    endtask

    task automatic test_halt();
        pc_auto = 0; pc_i = 0; trc_ready_i = 1;
        start_run();
        n_checks++;
        if (state_o !== 2'd1 || cycle_cnt_o !== 0) begin
            n_errors++;
            $display("FAIL halt_start: got st=%0d cyc=%0d, expected st=1 cyc=0", state_o, cycle_cnt_o);
        end
        for (int i = 1; i <= 30; i++) begin
            pc_i = (i <= 10) ? 32'(4 * i) : 32'd40;
            step();
            n_checks++;
            if (state_o !== m_state) begin
                n_errors++;
                $display("FAIL halt_state step %0d: got %0d, expected %0d", i, state_o, m_state);
            end
            if (m_state == 2'd2) break;
        end
        n_checks++;
        if (cycle_cnt_o !== 32'd14 || done_o !== 1'b1 || timeout_o !== 1'b0) begin
            n_errors++;
            $display("FAIL halt_end: got cyc=%0d done=%0d to=%0d, expected cyc=14 done=1 to=0",
                     cycle_cnt_o, done_o, timeout_o);
        end
        pc_auto = 1;
    endtask

    task automatic test_timeout();
        start_run();
        for (int i = 0; i < 450 && m_state == 2'd1; i++) step();
        n_checks++;
        if (cycle_cnt_o !== 32'd400 || timeout_o !== 1'b1 || done_o !== 1'b1 || state_o !== 2'd2) begin
            n_errors++;
            $display("FAIL timeout_end: got cyc=%0d to=%0d done=%0d st=%0d, expected 400/1/1/2",
                     cycle_cnt_o, timeout_o, done_o, state_o);
        end
        step();
        n_checks++;
        if (cycle_cnt_o !== 32'd400) begin
            n_errors++;
            $display("FAIL timeout_hold: got cyc=%0d, expected 400", cycle_cnt_o);
        end
    endtask

    task automatic test_trace_order();
        do_reset();
        start_run();
        trc_ready_i = 1;
        set_events(1, 5'd3, 32'd7, 0, 0, 0);
        step();
        n_checks++;
        if (trc_valid_o !== 1 || {trc_kind_o, trc_addr_o, trc_data_o} !== {1'b0, 32'd3, 32'd7} || trc_pc_o !== pc_i) begin
            n_errors++;
            $display("FAIL order_rf: got v=%0d k=%0d pc=%0d a=%0d d=%0d, expected v=1 k=0 pc=%0d a=3 d=7",
                     trc_valid_o, trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o, pc_i);
        end
        set_events(0, 0, 0, 1, 32'd8, 32'd5);
        step();
        n_checks++;
        if (trc_valid_o !== 1 || {trc_kind_o, trc_addr_o, trc_data_o} !== {1'b1, 32'd8, 32'd5}) begin
            n_errors++;
            $display("FAIL order_mem: got v=%0d k=%0d a=%0d d=%0d, expected v=1 k=1 a=8 d=5",
                     trc_valid_o, trc_kind_o, trc_addr_o, trc_data_o);
        end
        set_events(1, 5'd0, 32'd9, 0, 0, 0);
        step();
        set_events(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (trc_valid_o !== 0 || drop_cnt_o !== 0) begin
            n_errors++;
            $display("FAIL order_r0: got v=%0d drop=%0d, expected v=0 drop=0", trc_valid_o, drop_cnt_o);
        end
    endtask

    task automatic test_overflow();
        int n;
        do_reset();
        start_run();
        fill(10, 0);
        n_checks++;
        if (drop_cnt_o !== 16'd4 || overflow_o !== 1 || trc_valid_o !== 1) begin
            n_errors++;
            $display("FAIL ovf_counts: got drop=%0d ov=%0d v=%0d, expected drop=4 ov=1 v=1",
                     drop_cnt_o, overflow_o, trc_valid_o);
        end
        trc_ready_i = 1;
        n = 0;
        for (int i = 0; i < 24; i++) begin
            if (!trc_valid_o) break;
            n_checks++;
            if ({trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o} !== q[0]) begin
                n_errors++;
                $display("FAIL ovf_drain entry %0d: got %h, expected %h", i,
                         {trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o}, q[0]);
            end
            n++;
            step();
        end
        n_checks++;
        if (n != 16) begin
            n_errors++;
            $display("FAIL ovf_stored: got %0d entries, expected 16", n);
        end
    endtask

    task automatic test_odd_free(input bit with_pop);
        int  n;
        logic last_kind;
        do_reset();
        start_run();
        fill(7, 1);
        trc_ready_i = with_pop;
        set_events(1, 5'd4, 32'd44, 1, 32'd48, 32'd55);
        step();
        set_events(0, 0, 0, 0, 0, 0);
        trc_ready_i = 0;
        n_checks++;
        if (drop_cnt_o !== (with_pop ? 16'd0 : 16'd1) || overflow_o !== !with_pop) begin
            n_errors++;
            $display("FAIL odd_free pop=%0d: got drop=%0d ov=%0d, expected drop=%0d ov=%0d",
                     with_pop, drop_cnt_o, overflow_o, !with_pop, !with_pop);
        end
        trc_ready_i = 1;
        n = 0;
        last_kind = 1'bx;
        for (int i = 0; i < 24; i++) begin
            if (!trc_valid_o) break;
            last_kind = trc_kind_o;
            n++;
            step();
        end
        n_checks++;
        if (n != 16 || last_kind !== with_pop) begin
            n_errors++;
            $display("FAIL odd_free_drain pop=%0d: got n=%0d last_kind=%0d, expected n=16 last_kind=%0d",
                     with_pop, n, last_kind, with_pop);
        end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        start_run();
        for (int i = 0; i < 50; i++) begin
            trc_ready_i = ($urandom % 4) == 0;
            set_events(1, 5'($urandom_range(1, 31)), $urandom, $urandom % 2, $urandom, $urandom);
            step();
        end
        set_events(0, 0, 0, 0, 0, 0);
        n_checks++;
        if (cycle_cnt_o !== 32'd50 || trc_valid_o !== 1) begin
            n_errors++;
            $display("FAIL mid_before: got cyc=%0d v=%0d, expected cyc=50 v=1", cycle_cnt_o, trc_valid_o);
        end
        #2 rst_i = 1'b0;
        #1;
        n_checks++;
        if ({state_o, done_o, timeout_o, overflow_o, cycle_cnt_o, drop_cnt_o, trc_valid_o,
             trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o} !== '0) begin
            n_errors++;
            $display("FAIL mid_async: got st=%0d cyc=%0d drop=%0d ov=%0d v=%0d data=%h, expected all 0",
                     state_o, cycle_cnt_o, drop_cnt_o, overflow_o, trc_valid_o, trc_data_o);
        end
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        model_reset();
        trc_ready_i = 0;
        start_run();
        n_checks++;
        if (state_o !== 2'd1 || cycle_cnt_o !== 0 || trc_valid_o !== 0) begin
            n_errors++;
            $display("FAIL mid_restart: got st=%0d cyc=%0d v=%0d, expected st=1 cyc=0 v=0",
                     state_o, cycle_cnt_o, trc_valid_o);
        end
    endtask

    task automatic test_random();
        ent_t eh;
        do_reset();
        pc_auto = 0;
        for (int i = 0; i < 3000; i++) begin
            start_i     = ($urandom % 12) == 0;
            trc_ready_i = $urandom % 2;
            if (($urandom % 3) == 0) pc_i = 32'($urandom_range(0, 3) * 4);
            set_events(($urandom % 4) != 0, 5'($urandom_range(0, 3)), $urandom,
                       ($urandom % 3) == 0, $urandom, $urandom);
            step();
            eh = (q.size() != 0) ? q[0] : '0;
            n_checks++;
            if (state_o !== m_state || done_o !== (m_state == 2'd2)) begin
                n_errors++;
                $display("FAIL rnd_state %0d: got st=%0d dn=%0d, expected st=%0d", i, state_o, done_o, m_state);
            end
            n_checks++;
            if (cycle_cnt_o !== 32'(m_cyc) || timeout_o !== m_tmo) begin
                n_errors++;
                $display("FAIL rnd_cycle %0d: got cyc=%0d to=%0d, expected cyc=%0d to=%0d",
                         i, cycle_cnt_o, timeout_o, m_cyc, m_tmo);
            end
            n_checks++;
            if (drop_cnt_o !== m_drop || overflow_o !== m_ovf) begin
                n_errors++;
                $display("FAIL rnd_drop %0d: got drop=%0d ov=%0d, expected drop=%0d ov=%0d",
                         i, drop_cnt_o, overflow_o, m_drop, m_ovf);
            end
            n_checks++;
            if (trc_valid_o !== (q.size() != 0) || {trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o} !== eh) begin
                n_errors++;
                $display("FAIL rnd_head %0d: got v=%0d %h, expected v=%0d %h", i, trc_valid_o,
                         {trc_kind_o, trc_pc_o, trc_addr_o, trc_data_o}, q.size() != 0, eh);
            end
        end
        start_i = 0;
        pc_auto = 1;
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_halt();
        test_timeout();
        test_trace_order();
        test_overflow();
        test_odd_free(1'b1);
        test_odd_free(1'b0);
        test_reset_midrun();
        test_random();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/cpu_trace_monitor.md
# cpu_trace_monitor

Synthesizable run monitor and event-trace buffer that sits beside the single-cycle CPU and replaces the fixed-length, print-every-cycle checking style with hardware capture. It starts on command, counts cycles, records every register-file write and data-memory write into a parametrised FIFO, and stops on program halt or a cycle limit. A ready/valid port lets a bench or debug host drain the trace.

## Interface
- PC_W, 32, width of the program counter.
- DATA_W, 32, width of data and memory address.
- RADDR_W, 5, register index width.
- DEPTH, 16, trace FIFO entries; power of two, ≥ 2.
- MAX_CYCLES, 400, cycle limit per run; ≥ 1.
- HALT_CYCLES, 4, consecutive unchanged-PC cycles that define a halt; ≥ 1.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; one clock; reset is asynchronous and active-low.
- start_i  in  1  start-run pulse.
- pc_i  in  PC_W  CPU PC output.
- rf_we_i  in  1  register-file write enable.
- rf_waddr_i  in  RADDR_W  register write index.
- rf_wdata_i  in  DATA_W  register write data.
- mem_we_i  in  1  data-memory write enable.
- mem_addr_i  in  DATA_W  data-memory address.
- mem_wdata_i  in  DATA_W  data-memory write data.
- trc_valid_o  out  1  trace head entry valid.
- trc_ready_i  in  1  consumer accepts head entry.
- trc_kind_o  out  1  0 = register write, 1 = memory write.
- trc_pc_o  out  PC_W  PC at capture.
- trc_addr_o  out  DATA_W  register index (zero-extended) or memory address.
- trc_data_o  out  DATA_W  written value.
- state_o  out  2  0 IDLE, 1 RUN, 2 DONE.
- done_o  out  1  state is DONE.
- timeout_o  out  1  the last run ended on MAX_CYCLES.
- overflow_o  out  1  sticky; at least one event was dropped this run.
- cycle_cnt_o  out  32  RUN cycles elapsed.
- drop_cnt_o  out  16  events dropped; saturates at 16'hFFFF.

## Operation
- FSM transitions:
  - IDLE → RUN on start_i.
  - RUN → DONE on halt or timeout.
  - DONE → RUN on start_i.
  - start_i is ignored while in RUN.
- Entering RUN clears cycle_cnt, drop_cnt, overflow, timeout, the halt counter, the PC-valid flag, and the FIFO pointers. Unread trace is flushed.
- Events are sampled only on edges where the registered state is RUN.
  - Register event: rf_we_i=1 and rf_waddr_i≠0. Writes to R0 are never traced.
  - Memory event: mem_we_i=1.
- Dual push: when both events occur in the same cycle, the register entry is written at wr_ptr and the memory entry at wr_ptr+1.
- Free space = DEPTH − count + (pop this cycle). A pop frees its slot in the same cycle.
- Space shortfall:
  - Free space 1 with two events: the register entry is kept and the memory entry is dropped.
  - Free space 0: all events that cycle are dropped.
  - drop_cnt increments by the number dropped; overflow_o is set.
- Pop occurs when trc_valid_o=1 and trc_ready_i=1. Draining is allowed in every state, including concurrently with pushes in RUN.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- Halt detection:
  - prev_pc is registered every RUN edge.
  - same_cnt increments when the PC-valid flag is set and pc_i==prev_pc; otherwise it is zeroed.
  - The first RUN edge is always a mismatch.
  - Halt fires at the edge where same_cnt reaches HALT_CYCLES.
- Timeout: fires at the edge where cycle_cnt becomes MAX_CYCLES. timeout_o is set.
- If halt and timeout fire on the same edge, halt wins and timeout_o stays 0.
- Events on the terminating edge are still captured.
- In DONE, counters hold and no capture occurs.

## Timing
- Reset (rst_i=0, asynchronous): state IDLE and FIFO empty; every output is 0, including trc_* data.
- Reset asserted mid-run aborts immediately. There is no partial-state retention.
- start_i sampled at edge k: state_o=1 and cycle_cnt_o=0 after edge k. The first capture edge is k+1.
- Each RUN edge increments cycle_cnt_o by 1.
- Capture latency: an event sampled at edge n is visible at the FIFO head after edge n (trc_valid_o high in cycle n+1 if the FIFO was empty).
- trc_* outputs are driven from the head entry, with no extra read latency.
- trc_valid_o = (count≠0). It must not depend on trc_ready_i.
- The head entry is stable while valid=1 and ready=0.
- done_o and state_o update on the transition edge.

## Test plan
- **Halt:** reset, start; pc_i increments by 4 for 10 cycles, then holds at 40 → DONE exactly 4 edges after the hold begins; timeout_o=0, done_o=1.
- **Timeout:** MAX_CYCLES=400, pc_i always changing → DONE when cycle_cnt_o=400; timeout_o=1.
- **Trace order:** with trc_ready_i=1, write R3=7, then mem[8]=5, then R0=9 → entries (0,3,7) then (1,8,5); no R0 entry; drop_cnt_o=0.
- **Overflow:** DEPTH=16, trc_ready_i=0, 10 cycles with both rf and mem writes → 16 entries stored, 4 dropped; drop_cnt_o=4, overflow_o=1.
- **Odd free space:** count=15, dual event with a simultaneous pop → both stored, count=16, no drop. Same case without a pop → memory entry dropped.
- **Reset mid-run:** rst_i low at cycle 50 → all outputs 0 asynchronously, before the next edge; a new start gives cycle_cnt_o=0 and an empty FIFO.
